// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed image (count, words, checksum) and
// writes 16-bit words to instruction memory. Optional idle timeout: LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [2:0]            dbgState
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CNT_HI  = 3'd1;
  localparam logic [2:0] CNT_LO  = 3'd2;
  localparam logic [2:0] DATA_HI = 3'd3;
  localparam logic [2:0] DATA_LO = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERROR   = 3'd7;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  // Stream handshake: a byte moves on a rising edge only when in_valid and in_ready
  // are both high; in_ready depends on state alone, never on in_valid.
  logic [2:0]  state, nextState;
  logic [1:0]  nextErr;
  logic [7:0]  runSum, sumNext, cntHi, dataHi;
  logic [15:0] wordsLeft, countIn;
  logic        accept, restart, timeoutHit;

  assign in_ready   = (state == CNT_HI) || (state == CNT_LO) || (state == DATA_HI) ||
                      (state == DATA_LO) || (state == CHECK);
  assign accept     = in_valid && in_ready;
  assign restart    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign sumNext    = runSum + in_data;
  assign countIn    = {cntHi, in_data};
  assign cpu_hold   = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);
  assign dbgState   = state;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idleCnt;

  // Reaching the limit on the next edge counts as timing out on that edge.
  assign timeoutHit = in_ready && !accept && (idleCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                idleCnt <= '0;
    else if (!in_ready || accept) idleCnt <= '0;
    else                         idleCnt <= idleCnt + 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    nextState = state;
    nextErr   = err_code;
    case (state)
      IDLE:    if (start) nextState = CNT_HI;
      CNT_HI:  if (accept) nextState = CNT_LO;
      CNT_LO:
        if (accept) begin
          if ({1'b0, countIn} > MaxWords) begin
            nextState = ERROR;
            nextErr   = 2'b01;
          end else if (countIn == 16'd0) begin
            nextState = CHECK;
          end else begin
            nextState = DATA_HI;
          end
        end
      DATA_HI: if (accept) nextState = DATA_LO;
      DATA_LO: if (accept) nextState = (wordsLeft == 16'd1) ? CHECK : DATA_HI;
      CHECK:
        if (accept) begin
          if (sumNext == 8'd0) begin
            nextState = DONE;
          end else begin
            nextState = ERROR;
            nextErr   = 2'b10;
          end
        end
      DONE, ERROR:
        if (start) begin
          nextState = CNT_HI;
          nextErr   = 2'b00;
        end
      default: nextState = IDLE;
    endcase
    if (timeoutHit) begin
      nextState = ERROR;
      nextErr   = 2'b11;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      err_code <= 2'b00;
      runSum   <= 8'd0;
      cntHi    <= 8'd0;
      dataHi   <= 8'd0;
      wordsLeft <= 16'd0;
    end else begin
      state    <= nextState;
      err_code <= nextErr;
      if (restart)     runSum <= 8'd0;
      else if (accept) runSum <= sumNext;
      if (accept && state == CNT_HI)  cntHi  <= in_data;
      if (accept && state == DATA_HI) dataHi <= in_data;
      if (accept && state == CNT_LO)       wordsLeft <= countIn;
      else if (accept && state == DATA_LO) wordsLeft <= wordsLeft - 16'd1;
    end
  end

  // Write port: registered one cycle after the low byte; address is the pre-increment count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 16'd0;
      words_written <= '0;
    end else begin
      mem_we <= accept && (state == DATA_LO);
      if (accept && state == DATA_LO) begin
        mem_addr      <= words_written[ADDR_WIDTH-1:0];
        mem_wdata     <= {dataHi, in_data};
        words_written <= words_written + 1'b1;
      end else if (restart) begin
        words_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized frames for imem_loader, checked against a frame-level model.
module tb_imem_loader;
  localparam int AW = 8;
  localparam int MAXW = 256;
  localparam int TMO = 16;

  logic          clock, reset_n, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_hold, load_done, load_error;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    err_code;
  logic [AW:0]   words_written;
  logic [2:0]    dbgState;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .err_code(err_code), .words_written(words_written),
    .dbgState(dbgState)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [AW+15:0] exp_q[$];
  logic [7:0]     frame_q[$];
  logic           exp_done, exp_err;
  logic [1:0]     exp_code;
  int             exp_words;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr, data}
  always @(negedge clock) begin
    if (reset_n === 1'b1 && mem_we === 1'b1) begin
      logic [AW+15:0] e;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected none", mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", {8'h0, mem_addr, mem_wdata}, {8'h0, e});
        check("words_at_write", 32'(words_written), 32'(e[AW+15:16]) + 1);
      end
    end
  end

  // reference model: interpret the frame in frame_q from the frame rules
  task automatic model_frame();
    int n, sum;
    n = {frame_q[0], frame_q[1]};
    if (n > MAXW) begin
      exp_done = 0; exp_err = 1; exp_code = 2'b01; exp_words = 0;
      return;
    end
    sum = 0;
    foreach (frame_q[i]) sum += frame_q[i];
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), frame_q[2 + 2*i], frame_q[3 + 2*i]});
    exp_words = n;
    exp_done = ((sum % 256) == 0);
    exp_err  = !exp_done;
    exp_code = exp_done ? 2'b00 : 2'b10;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps, input bit poke);
    int w;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clock);
      in_valid = 1'b0;
      start = poke;
    end
    @(negedge clock);
    start = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (w >= 50) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 valid toggles every other cycle, 2 random gaps and start pokes
  task automatic run_frame(input string tag, input int gapMode, input bit doStart);
    model_frame();
    if (doStart) pulse_start();
    foreach (frame_q[i]) begin
      int gaps;
      gaps = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(frame_q[i], gaps, (gapMode == 2) && ($urandom_range(0, 3) == 0));
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_error"}, 32'(load_error), 32'(exp_err));
    check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_words"}, 32'(words_written), 32'(exp_words));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
  endtask

  task automatic set_nominal(input logic [7:0] chk);
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk};
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_reset();

    set_nominal(8'h40);
    run_frame("nominal", 0, 1);
    set_nominal(8'h41);
    run_frame("badsum", 0, 1);
    frame_q = '{8'h01, 8'h01};
    run_frame("toolarge", 0, 1);
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("zerolen", 0, 1);
    set_nominal(8'h40);
    run_frame("toggled", 1, 1);

    // reset in the middle of a load
    pulse_start();
    send_byte(8'h00, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h12, 0, 0);
    @(negedge clock);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_hold", 32'(cpu_hold), 32'd1);
    check("midreset_ready", 32'(in_ready), 32'd0);
    check("midreset_words", 32'(words_written), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // start together with a valid byte in IDLE: that byte must be dropped
    @(negedge clock);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b0;
    set_nominal(8'h40);
    run_frame("after_reset", 0, 0);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      int n, sum;
      frame_q.delete();
      n = ($urandom_range(0, 8) == 0) ? 257 + int'($urandom_range(0, 600)) : int'($urandom_range(0, 6));
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      if (n <= MAXW) begin
        sum = frame_q[0] + frame_q[1];
        for (int i = 0; i < 2 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          frame_q.push_back(b);
          sum += b;
        end
        sum = (256 - (sum % 256)) % 256;
        if ($urandom_range(0, 3) == 0) sum = (sum + int'($urandom_range(1, 255))) % 256;
        frame_q.push_back(8'(sum));
      end
      run_frame("random", int'($urandom_range(0, 2)), 1);
    end

    // stall mid-frame with no traffic
    pulse_start();
    send_byte(8'h00, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h12, 0, 0);
    @(negedge clock);
    in_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    repeat (TMO + 4) @(negedge clock);
    check("timeout_error", 32'(load_error), 32'd1);
    check("timeout_code", 32'(err_code), 32'd3);
    check("timeout_hold", 32'(cpu_hold), 32'd1);
`else
    repeat (3 * TMO) @(negedge clock);
    check("stall_error", 32'(load_error), 32'd0);
    check("stall_ready", 32'(in_ready), 32'd1);
    check("stall_hold", 32'(cpu_hold), 32'd1);
`endif
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the instruction fetch path.
- Receives a framed program image over an 8-bit valid/ready stream and writes 16-bit instruction words into instruction memory from address 0.
- Holds the processor pipeline (`cpu_hold`) until the image is complete and its checksum is correct.
- Sits between the host/debug link and the instruction memory write port, beside the fetch stage.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 1024, idle-cycle limit used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  16  instruction word.
- cpu_hold  output  1  pipeline held (PC and IFID frozen) while 1.
- load_done  output  1  image loaded and checksum matched.
- load_error  output  1  load aborted.
- err_code  output  2  01 = count too large, 10 = checksum mismatch, 11 = timeout.
- words_written  output  ADDR_WIDTH+1  words written in the current load.

Behaviour:
- Reset is asynchronous and active-low; clock is the single clock. reset_n low forces IDLE immediately.
- Reset values: cpu_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_error=0, err_code=00, words_written=0.
- Frame format, big-endian: CNT_HI, CNT_LO, then N words sent as HI byte followed by LO byte, then CHK.
- A frame is valid when the 8-bit sum of every byte including CHK equals 0x00.
- A byte transfers only on a clock edge where in_valid=1 and in_ready=1.
- in_ready=1 in states CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK; in_ready=0 in IDLE, DONE, ERROR.
- Running sum: cleared on the start that leaves IDLE/DONE/ERROR; updated on every accepted byte.
- State transitions:
  - IDLE --start--> CNT_HI.
  - CNT_HI --byte--> CNT_LO.
  - CNT_LO --byte--> then:
    - N > MAX_WORDS → ERROR with err_code=01.
    - N = 0 → CHECK.
    - otherwise → DATA_HI.
  - DATA_HI --byte--> DATA_LO; the byte is latched as the high half of the word.
  - DATA_LO --byte--> DATA_HI if more words remain, else CHECK.
  - CHECK --byte--> then:
    - sum = 0 → DONE.
    - sum ≠ 0 → ERROR with err_code=10.
- Word write (one-cycle latency):
  - The cycle after the DATA_LO byte is accepted, mem_we=1 for exactly one cycle.
  - In that cycle mem_wdata={hi, lo} and mem_addr=words_written (pre-increment value).
  - words_written increments on the same edge that raises mem_we.
  - Back-to-back bytes are accepted during the write cycle; there is no stall.
- mem_addr holds its last value when mem_we=0. The address never wraps, because N ≤ MAX_WORDS is enforced.
- DONE: cpu_hold=0, load_done=1; both hold until the next start.
- ERROR: cpu_hold stays 1, load_error=1; both hold until the next start.
- start while in CNT_HI..CHECK is ignored.
- start in DONE or ERROR performs a fresh load:
  - cpu_hold=1, load_done=0, load_error=0, err_code=00, words_written=0, and the running sum is cleared.
  - Memory contents are not cleared.
- start and in_valid in the same cycle while in IDLE: the byte is not accepted, because in_ready=0 in IDLE.
- Reset asserted mid-load: returns to IDLE with reset values and cpu_hold=1. A partial image remains in memory.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in CNT_HI..CHECK and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES → ERROR with err_code=11; cpu_hold stays 1.
  - The counter is held at 0 outside CNT_HI..CHECK.
- Undefined:
  - No counter logic is built; the loader waits indefinitely.
  - err_code 11 is never produced.

Test Plan:
- Nominal load: reset, start, then bytes 00 02 12 34 AB CD 40 → mem_we pulses with (addr 0, data 0x1234) and (addr 1, data 0xABCD); words_written=2; load_done=1; cpu_hold=0; err_code=00.
- Checksum mismatch: same frame with CHK=41 → both words still written; load_error=1; err_code=10; cpu_hold=1.
- Count too large (MAX_WORDS=256): bytes 01 01 → ERROR after the second byte; err_code=01; no mem_we pulses; in_ready=0.
- Zero-length frame: bytes 00 00 00 → load_done=1; words_written=0; no mem_we pulses.
- Disruptions: in_valid toggled every other cycle during the nominal frame → identical writes to the nominal load. reset_n low after 3 bytes → immediate IDLE, cpu_hold=1; a fresh start plus the nominal frame then succeeds.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16): start, bytes 00 02 12, then idle for 16 cycles → load_error=1, err_code=11. Without the macro, the same stimulus stays in DATA_LO indefinitely.
